// File: rtl/sram_ctrl_pkg.sv
// Shared FSM state encoding, phase lengths and beat-search helper for the async SRAM controller.
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RESP
   } state_e;

   localparam int SETUP_CYCLES = 1;
   localparam int HOLD_CYCLES  = 1;

   // Index of the lowest set bit of mask in [from, n), or -1 when there is none.
   function automatic int lowest_set(input logic [63:0] mask, input int from, input int n);
      int r = -1;
      for (int i = 63; i >= 0; i--) begin
         if (i >= from && i < n && mask[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/sram_ctrl_timer.sv
// STROBE-phase down-counter: load sets WAIT_CYCLES, done_o flags zero; 1 + WAIT_CYCLES cycles per load.
module sram_ctrl_timer #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic done_o
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = 4'(WAIT_CYCLES);
      end else if (en_i && cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/sram_ctrl.sv
// Byte-serial async SRAM controller: BEATS*(WAIT_CYCLES+3)+1 cycle access, single outstanding request,
// response held until rsp_ready_i. SRAM_CTRL_BYTE_STRB_EN adds req_strb_i to skip disabled write bytes.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1,
   localparam int BEATS      = DATA_W / 8,
   localparam int LB         = $clog2(BEATS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [ADDR_W-LB-1:0] req_addr_i,
   input  logic [DATA_W-1:0]    req_wdata_i,
`ifdef SRAM_CTRL_BYTE_STRB_EN
   input  logic [BEATS-1:0]     req_strb_i,
`endif
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DATA_W-1:0]    rsp_rdata_o,
   output logic                 sram_cs_no,
   output logic                 sram_we_no,
   output logic                 sram_oe_no,
   output logic [ADDR_W-1:0]    sram_addr_o,
   output logic [7:0]           sram_wdata_o,
   output logic                 sram_wdata_oe_o,
   input  logic [7:0]           sram_rdata_i
);

   localparam int KW = (LB > 0) ? LB : 1;

   state_e                state_q, state_d;
   logic [KW-1:0]         k_q, k_d;
   logic                  we_q, we_d;
   logic [ADDR_W-LB-1:0]  waddr_q, waddr_d;
   logic [DATA_W-1:0]     wbuf_q, wbuf_d;
   logic [BEATS-1:0]      strb_q, strb_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;

   logic                  cs_n_q, cs_n_d;
   logic                  we_n_q, we_n_d;
   logic                  oe_n_q, oe_n_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [7:0]            wdata_q, wdata_d;
   logic                  wdata_oe_q, wdata_oe_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  req_ready_q, req_ready_d;

   logic                  timer_load;
   logic                  timer_en;
   logic                  timer_done;
   logic                  strobe_nxt;
   logic                  active_nxt;
   int                    nb;

   sram_ctrl_timer #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_timer (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .load_i(timer_load),
      .en_i  (timer_en),
      .done_o(timer_done)
   );

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      we_d       = we_q;
      waddr_d    = waddr_q;
      wbuf_d     = wbuf_q;
      strb_d     = strb_q;
      rdata_d    = rdata_q;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      nb         = -1;

      unique case (state_q)
         IDLE: begin
            if (req_valid_i && req_ready_q) begin
               we_d    = req_we_i;
               waddr_d = req_addr_i;
               wbuf_d  = req_wdata_i;
               rdata_d = '0;
`ifdef SRAM_CTRL_BYTE_STRB_EN
               strb_d  = req_we_i ? req_strb_i : '1;
`else
               strb_d  = '1;
`endif
               // A write with no enabled byte has nothing to strobe and answers at once.
               nb = lowest_set(64'(strb_d), 0, BEATS);
               if (nb < 0) begin
                  state_d = RESP;
               end else begin
                  k_d     = KW'(nb);
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            timer_load = 1'b1;
            state_d    = STROBE;
         end
         STROBE: begin
            if (timer_done) begin
               if (!we_q) rdata_d[{k_q, 3'b000} +: 8] = sram_rdata_i;
               state_d = HOLD;
            end else begin
               timer_en = 1'b1;
            end
         end
         HOLD: begin
            nb = lowest_set(64'(strb_q), int'(k_q) + 1, BEATS);
            if (nb < 0) begin
               state_d = RESP;
            end else begin
               k_d     = KW'(nb);
               state_d = SETUP;
            end
         end
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Pin values are decoded from the next state so every SRAM output leaves a flop.
      strobe_nxt  = (state_d == STROBE);
      active_nxt  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
      cs_n_d      = !strobe_nxt;
      we_n_d      = !(strobe_nxt && we_d);
      oe_n_d      = !(strobe_nxt && !we_d);
      wdata_oe_d  = active_nxt && we_d;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if (state_d == SETUP) begin
         addr_d  = (ADDR_W'(waddr_d) << LB) | ADDR_W'(k_d);
         wdata_d = we_d ? wbuf_d[{k_d, 3'b000} +: 8] : 8'h00;
      end
      rsp_valid_d = (state_d == RESP);
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         k_q         <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wbuf_q      <= '0;
         strb_q      <= '0;
         rdata_q     <= '0;
         cs_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         wdata_oe_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wbuf_q      <= wbuf_d;
         strb_q      <= strb_d;
         rdata_q     <= rdata_d;
         cs_n_q      <= cs_n_d;
         we_n_q      <= we_n_d;
         oe_n_q      <= oe_n_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wdata_oe_q  <= wdata_oe_d;
         rsp_valid_q <= rsp_valid_d;
         req_ready_q <= req_ready_d;
      end
   end

   assign req_ready_o     = req_ready_q;
   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_rdata_o     = rdata_q;
   assign sram_cs_no      = cs_n_q;
   assign sram_we_no      = we_n_q;
   assign sram_oe_no      = oe_n_q;
   assign sram_addr_o     = addr_q;
   assign sram_wdata_o    = wdata_q;
   assign sram_wdata_oe_o = wdata_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with DATA_W=32, WAIT_CYCLES=1 and a byte-wide SRAM model.
module tb_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready_o;
   logic        req_we = 1'b0;
   logic [11:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_strb = 4'hF;
   logic        rsp_valid_o;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata_o;
   logic        sram_cs_no, sram_we_no, sram_oe_no;
   logic [13:0] sram_addr_o;
   logic [7:0]  sram_wdata_o;
   logic        sram_wdata_oe_o;
   logic [7:0]  sram_rdata_i;

   logic [7:0]  mem [0:16383];

   int n_tests = 0;
   int n_fail  = 0;

   int          we_cnt = 0;
   int          cs_cnt = 0;
   int          oe_low_cycles = 0;
   int          viol = 0;
   logic [13:0] we_addr [0:63];
   logic [7:0]  we_dat  [0:63];
   logic        prev_we_n = 1'b1;
   logic        prev_cs_n = 1'b1;

   always #5 clk = ~clk;

   assign sram_rdata_i = mem[sram_addr_o];

   sram_ctrl #(
      .ADDR_W(14),
      .DATA_W(32),
      .WAIT_CYCLES(1)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
`ifdef SRAM_CTRL_BYTE_STRB_EN
      .req_strb_i     (req_strb),
`endif
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready),
      .rsp_rdata_o    (rsp_rdata_o),
      .sram_cs_no     (sram_cs_no),
      .sram_we_no     (sram_we_no),
      .sram_oe_no     (sram_oe_no),
      .sram_addr_o    (sram_addr_o),
      .sram_wdata_o   (sram_wdata_o),
      .sram_wdata_oe_o(sram_wdata_oe_o),
      .sram_rdata_i   (sram_rdata_i)
   );

   // Bus monitor: logs each WE pulse start and counts protocol violations.
   always @(negedge clk) begin
      if (!sram_we_no && prev_we_n) begin
         if (we_cnt < 64) begin
            we_addr[we_cnt] = sram_addr_o;
            we_dat[we_cnt]  = sram_wdata_o;
         end
         we_cnt++;
      end
      if (!sram_cs_no && prev_cs_n) cs_cnt++;
      if (!sram_oe_no) oe_low_cycles++;
      if (!sram_we_no && !sram_oe_no) viol++;
      if (sram_wdata_oe_o && !sram_oe_no) viol++;
      if (!sram_we_no && (!sram_wdata_oe_o || sram_cs_no)) viol++;
      prev_we_n = sram_we_no;
      prev_cs_n = sram_cs_no;
   end

   // Issue one request and return the cycle (acceptance = 0) in which rsp_valid_o is first seen.
   task automatic issue(input logic we, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_strb  = s;
      n = 0;
      while (!req_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         if (rsp_valid_o) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", req_ready_o); end
      n_tests++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
      n_tests++; if (rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rsp_rdata_o); end
      n_tests++; if ({sram_cs_no, sram_we_no, sram_oe_no} !== 3'b111) begin n_fail++; $display("FAIL reset_ctrl got %b want 111", {sram_cs_no, sram_we_no, sram_oe_no}); end
      n_tests++; if (sram_wdata_oe_o !== 1'b0) begin n_fail++; $display("FAIL reset_wdata_oe got %b want 0", sram_wdata_oe_o); end
      n_tests++; if (sram_addr_o !== 14'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", sram_addr_o); end
      n_tests++; if (sram_wdata_o !== 8'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", sram_wdata_o); end
      rst_i = 1'b0;
      @(negedge clk);
      n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b want 1", req_ready_o); end
   endtask

   task automatic test_read;
      int lat;
      int oe0;
      int we0;
      oe0 = oe_low_cycles;
      we0 = we_cnt;
      rsp_ready = 1'b1;
      issue(1'b0, 12'h010, 32'h0, 4'hF, lat);
      n_tests++; if (lat != 17) begin n_fail++; $display("FAIL read_latency got %0d want 17", lat); end
      n_tests++; if (rsp_rdata_o !== 32'h44332211) begin n_fail++; $display("FAIL read_data got %h want 44332211", rsp_rdata_o); end
      @(negedge clk);
      n_tests++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL read_rsp_drop got %b want 0", rsp_valid_o); end
      n_tests++; if (oe_low_cycles - oe0 != 8) begin n_fail++; $display("FAIL read_oe_cycles got %0d want 8", oe_low_cycles - oe0); end
      n_tests++; if (we_cnt != we0) begin n_fail++; $display("FAIL read_we_pulses got %0d want 0", we_cnt - we0); end
   endtask

   task automatic test_write;
      int lat;
      int base;
      int oe0;
      logic [31:0] wd;
      wd   = 32'hA5B6C7D8;
      base = we_cnt;
      oe0  = oe_low_cycles;
      rsp_ready = 1'b1;
      issue(1'b1, 12'h003, wd, 4'hF, lat);
      n_tests++; if (lat != 17) begin n_fail++; $display("FAIL write_latency got %0d want 17", lat); end
      n_tests++; if (rsp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL write_rdata got %h want 0", rsp_rdata_o); end
      n_tests++; if (we_cnt - base != 4) begin n_fail++; $display("FAIL write_pulses got %0d want 4", we_cnt - base); end
      n_tests++; if (oe_low_cycles != oe0) begin n_fail++; $display("FAIL write_oe_low got %0d want 0", oe_low_cycles - oe0); end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (we_addr[base+i] !== 14'(12 + i) || we_dat[base+i] !== wd[8*i +: 8]) begin
            n_fail++;
            $display("FAIL write_beat%0d got addr %h data %h want addr %h data %h",
                     i, we_addr[base+i], we_dat[base+i], 14'(12 + i), wd[8*i +: 8]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int lat;
      int we0;
      we0 = we_cnt;
      rsp_ready = 1'b0;
      issue(1'b0, 12'h010, 32'h0, 4'hF, lat);
      n_tests++; if (lat != 17) begin n_fail++; $display("FAIL bp_latency got %0d want 17", lat); end
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 12'h020;
      req_wdata = 32'hCAFEF00D;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h44332211 || req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d got valid %b data %h ready %b want 1 44332211 0",
                     i, rsp_valid_o, rsp_rdata_o, req_ready_o);
         end
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_release got %b want 0", rsp_valid_o); end
      n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after got %b want 1", req_ready_o); end
      repeat (20) @(negedge clk);
      n_tests++; if (we_cnt != we0) begin n_fail++; $display("FAIL bp_second_req got %0d pulses want 0", we_cnt - we0); end
   endtask

   task automatic test_reset_mid;
      int n;
      int we0;
      int cs0;
      logic seen_rsp;
      we0 = we_cnt;
      cs0 = cs_cnt;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 12'h005;
      req_wdata = 32'h01020304;
      n = 0;
      while (!req_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
      end
      n_tests++; if (sram_we_no !== 1'b0 || sram_addr_o !== 14'h15) begin n_fail++; $display("FAIL mid_strobe got we_n %b addr %h want 0 15", sram_we_no, sram_addr_o); end
      rst_i = 1'b1;
      @(negedge clk);
      n_tests++; if ({sram_cs_no, sram_we_no, sram_oe_no} !== 3'b111) begin n_fail++; $display("FAIL mid_ctrl got %b want 111", {sram_cs_no, sram_we_no, sram_oe_no}); end
      n_tests++; if (sram_wdata_oe_o !== 1'b0) begin n_fail++; $display("FAIL mid_wdata_oe got %b want 0", sram_wdata_oe_o); end
      rst_i = 1'b0;
      seen_rsp = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rsp_valid_o) seen_rsp = 1'b1;
      end
      n_tests++; if (seen_rsp !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp got %b want 0", seen_rsp); end
      n_tests++; if (we_cnt - we0 != 2 || cs_cnt - cs0 != 2) begin n_fail++; $display("FAIL mid_strobes got we %0d cs %0d want 2 2", we_cnt - we0, cs_cnt - cs0); end
      n_tests++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after got %b want 1", req_ready_o); end
   endtask

`ifdef SRAM_CTRL_BYTE_STRB_EN
   task automatic test_strobe;
      int lat;
      int base;
      rsp_ready = 1'b1;
      base = we_cnt;
      issue(1'b1, 12'h007, 32'hDEADBEEF, 4'b0101, lat);
      n_tests++; if (lat != 9) begin n_fail++; $display("FAIL strb_latency got %0d want 9", lat); end
      n_tests++; if (we_cnt - base != 2) begin n_fail++; $display("FAIL strb_pulses got %0d want 2", we_cnt - base); end
      n_tests++; if (we_addr[base] !== 14'h1C || we_dat[base] !== 8'hEF) begin n_fail++; $display("FAIL strb_beat0 got %h %h want 1c ef", we_addr[base], we_dat[base]); end
      n_tests++; if (we_addr[base+1] !== 14'h1E || we_dat[base+1] !== 8'hAD) begin n_fail++; $display("FAIL strb_beat2 got %h %h want 1e ad", we_addr[base+1], we_dat[base+1]); end
      base = we_cnt;
      issue(1'b1, 12'h007, 32'h12345678, 4'b0000, lat);
      n_tests++; if (lat != 1) begin n_fail++; $display("FAIL strb_zero_latency got %0d want 1", lat); end
      n_tests++; if (we_cnt != base) begin n_fail++; $display("FAIL strb_zero_pulses got %0d want 0", we_cnt - base); end
      issue(1'b0, 12'h010, 32'h0, 4'b0000, lat);
      n_tests++; if (lat != 17 || rsp_rdata_o !== 32'h44332211) begin n_fail++; $display("FAIL strb_read got lat %0d data %h want 17 44332211", lat, rsp_rdata_o); end
      @(negedge clk);
   endtask
`endif

   task automatic test_protocol;
      n_tests++; if (viol != 0) begin n_fail++; $display("FAIL protocol_violations got %0d want 0", viol); end
   endtask

   initial begin
      mem[14'h40] = 8'h11;
      mem[14'h41] = 8'h22;
      mem[14'h42] = 8'h33;
      mem[14'h43] = 8'h44;
      test_reset();
      test_read();
      test_write();
      test_backpressure();
      test_reset_mid();
`ifdef SRAM_CTRL_BYTE_STRB_EN
      test_strobe();
`endif
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
